pc_gen: RTL
===========

# pc_gen

Fetch-stage program-counter generator: owns the PC register and resolves the next PC each cycle. Sources are sequential increment, conditional branch, 26-bit jump, register jump and exception vector. It adds stall hold, a one-entry pending-redirect buffer for redirects that arrive during a stall, and a registered flush pulse. It sits between the instruction-memory address port and the decode-stage control/compare logic.

## Interface
Parameters:
- ADDR_W, 32, PC width; must be ≥ 32
- RESET_PC, 32'h0000_3000, PC value loaded by reset
- EXC_VEC, 32'h0000_4180, PC value loaded on exception or address error

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold pcF this cycle
- excReq  in  1  exception redirect; overrides stall
- brTaken  in  1  conditional branch resolved taken (one-cycle pulse)
- jump  in  1  j/jal redirect (one-cycle pulse)
- jr  in  1  jr/jalr redirect (one-cycle pulse)
- pcD  in  ADDR_W  PC of the instruction that issued the redirect
- offset  in  ADDR_W  sign-extended branch word offset
- imm26  in  26  jump index field
- rsData  in  ADDR_W  register-jump target
- pcF  out  ADDR_W  current fetch PC (registered)
- pcPlus4F  out  ADDR_W  pcF + 4 (combinational from pcF)
- npc  out  ADDR_W  value pcF takes at the next edge (combinational)
- redirected  out  1  registered pulse: pcF was loaded from a non-sequential source at the last edge
- pendValid  out  1  pending-redirect buffer occupied
- addrErr  out  1  registered pulse: misaligned jr target trapped (see Configuration)

## Operation
Target selection applies when several redirect pulses are high together. Priority: jr > brTaken > jump.
- jr target: rsData
- branch target: pcD + 4 + (offset << 2), modulo 2^ADDR_W
- jump target: {pcD[ADDR_W-1:28], imm26, 2'b00}

req = jr | brTaken | jump.

Next-PC rules, in priority order:
1. excReq → EXC_VEC; pending buffer cleared; redirected = 1.
2. stall → pcF held.
   - If req: pendTarget ← the selected target and pendValid ← 1. A later request while still stalled overwrites the buffer.
   - redirected = 0.
3. req → selected target; pending buffer cleared; redirected = 1. A live request beats a buffered one.
4. pendValid → pendTarget; pendValid ← 0; redirected = 1.
5. Otherwise → pcF + 4; redirected = 0.

Buffer behaviour:
- The pending buffer acts as a two-state FSM, EMPTY and FULL.
- EMPTY→FULL on stall & req & !excReq.
- FULL→EMPTY on excReq, or on any non-stalled cycle.

Other rules:
- npc always equals the value chosen by the rules above for the current cycle.
- Arithmetic wraps at 2^ADDR_W. No overflow is flagged.

## Timing
- Reset (asynchronous) sets pcF = RESET_PC, pendValid = 0, redirected = 0, addrErr = 0, pendTarget = 0.
- Releasing reset causes no extra bubble: the first edge after release loads RESET_PC + 4, or a redirect if one is present.
- Redirect latency: a pulse in cycle n appears on pcF after edge n. redirected is high in cycle n+1.
- Buffered redirect: applied on the first edge whose cycle has stall = 0, i.e. one cycle after stall drops.
- excReq during stall still loads EXC_VEC at the next edge and discards the buffer.
- Redirect pulses with stall = 0 and excReq = 1 are discarded.
- Inputs must be stable before the edge. The block adds no input registering.

## Configuration
PC_ALIGN_CHK_EN is the only compile-time option.
- Defined:
  - A jr target with rsData[1:0] ≠ 0 is not loaded. It is treated as rule 1: pcF ← EXC_VEC, buffer cleared, redirected = 1.
  - addrErr pulses for one cycle after that edge.
  - The check applies when the target is loaded, whether live or from the buffer.
- Undefined:
  - Bits [1:0] of every jr target are forced to 00.
  - addrErr is tied to 0.

## Test plan
- Reset then 3 free cycles → pcF = 0x3000, 0x3004, 0x3008, 0x300C; redirected stays 0.
- brTaken with pcD = 0x3010, offset = 0xFFFF_FFFC → pcF = 0x3004 next cycle; redirected = 1 for one cycle.
- stall = 1 for 3 cycles with a jump pulse (pcD = 0x3020, imm26 = 0x0000C40) in the first stalled cycle → pcF held and pendValid = 1. After stall drops, pcF = 0x0000_3100; pendValid = 0.
- jr and brTaken in the same cycle, rsData = 0x3400 → pcF = 0x3400. Then excReq during a stall with pendValid = 1 → pcF = 0x4180 and pendValid = 0.
- jr with rsData = 0x3402:
  - With PC_ALIGN_CHK_EN: pcF = 0x4180 and addrErr pulses.
  - Without: pcF = 0x3400 and addrErr = 0.
- Assert reset mid-stall with pendValid = 1 → immediately pcF = 0x3000 and all flags 0, with no clock edge needed.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with stall hold and pending-redirect buffer
// Optional feature macro: PC_ALIGN_CHK_EN (trap misaligned jr targets to EXC_VEC and pulse addrErr)
module pc_gen #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC  = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              excReq,
  input  logic              brTaken,
  input  logic              jump,
  input  logic              jr,
  input  logic [ADDR_W-1:0] pcD,
  input  logic [ADDR_W-1:0] offset,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] rsData,
  output logic [ADDR_W-1:0] pcF,
  output logic [ADDR_W-1:0] pcPlus4F,
  output logic [ADDR_W-1:0] npc,
  output logic              redirected,
  output logic              pendValid,
  output logic              addrErr
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              pend_bad_q, pend_bad_d;
  logic              redir_q, redir_d;
  logic              addr_err_q, addr_err_d;

  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] jmp_tgt;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] sel_tgt;
  logic              live_bad;
  logic              req;

  // Candidate redirect targets; all arithmetic wraps at ADDR_W bits
  always_comb begin
    br_tgt  = pcD + ADDR_W'(4) + (offset << 2);
    jmp_tgt = {pcD[ADDR_W-1:28], imm26, 2'b00};
`ifdef PC_ALIGN_CHK_EN
    jr_tgt   = rsData;
    live_bad = jr & (rsData[1:0] != 2'b00);
`else
    jr_tgt   = rsData & ~{{(ADDR_W-2){1'b0}}, 2'b11};
    live_bad = 1'b0;
`endif
    req = jr | brTaken | jump;
    if (jr)           sel_tgt = jr_tgt;
    else if (brTaken) sel_tgt = br_tgt;
    else              sel_tgt = jmp_tgt;
  end

  // Next-PC resolution and pending-buffer FSM next state
  always_comb begin
    pc_d          = pc_q + ADDR_W'(4);
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pend_bad_d    = pend_bad_q;
    redir_d       = 1'b0;
    addr_err_d    = 1'b0;
    if (excReq) begin
      pc_d    = EXC_VEC;
      state_d = BUF_EMPTY;
      redir_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
      if (req) begin
        // A newer request while stalled replaces whatever is buffered
        pend_target_d = sel_tgt;
        pend_bad_d    = live_bad;
        state_d       = BUF_FULL;
      end
    end else if (req) begin
      state_d = BUF_EMPTY;
      redir_d = 1'b1;
      if (live_bad) begin
        pc_d       = EXC_VEC;
        addr_err_d = 1'b1;
      end else begin
        pc_d = sel_tgt;
      end
    end else if (state_q == BUF_FULL) begin
      state_d = BUF_EMPTY;
      redir_d = 1'b1;
      if (pend_bad_q) begin
        pc_d       = EXC_VEC;
        addr_err_d = 1'b1;
      end else begin
        pc_d = pend_target_q;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      state_q       <= BUF_EMPTY;
      pend_target_q <= '0;
      pend_bad_q    <= 1'b0;
      redir_q       <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
      pend_bad_q    <= pend_bad_d;
      redir_q       <= redir_d;
      addr_err_q    <= addr_err_d;
    end
  end

  // Output drive
  always_comb begin
    pcF        = pc_q;
    pcPlus4F   = pc_q + ADDR_W'(4);
    npc        = pc_d;
    redirected = redir_q;
    pendValid  = (state_q == BUF_FULL);
`ifdef PC_ALIGN_CHK_EN
    addrErr    = addr_err_q;
`else
    addrErr    = 1'b0;
`endif
  end

endmodule
